// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode encodings, receiver state type and baud divisor helper.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_rx_state_t;

  // Clock cycles per bit, truncated.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; head data reads as zero while empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_valid,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_valid   = (r_count != '0);
  assign o_full    = (r_count == FULL_CNT);
  assign o_count   = r_count;
  assign w_do_pop  = i_pop && o_valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = o_valid ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/uart_rx_param.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM and show-ahead receive FIFO.
// Malformed or overflowing frames are dropped and reported with single-cycle error pulses.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = PAR_NONE,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic                          UART_RX,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD);
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic             ODD_PAR   = (PARITY == PAR_ODD);

  if (DIV < 4 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > PAR_EVEN ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uart_rx_param: illegal parameter combination");
  end

  logic [1:0]           r_sync;
  logic                 w_rxs;
  uart_rx_state_t       r_state, w_state_d;
  logic [CNT_W-1:0]     r_baudcnt, w_baudcnt_d;
  logic [BIT_W-1:0]     r_bitcnt, w_bitcnt_d;
  logic [DATA_BITS-1:0] r_shift, w_shift_d;
  logic                 r_par_bad, w_par_bad_d;
  logic                 r_parity_err, w_parity_err_d;
  logic                 r_frame_err, w_frame_err_d;
  logic                 r_overrun, w_overrun_d;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_baud_tick;

  assign w_rxs       = r_sync[1];
  assign w_pop       = rx_valid & rx_ready;
  assign w_baud_tick = (r_baudcnt == FULL_LAST);
  assign parity_err  = r_parity_err;
  assign frame_err   = r_frame_err;
  assign overrun     = r_overrun;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_sync       <= 2'b11;
      r_state      <= StIdle;
      r_baudcnt    <= '0;
      r_bitcnt     <= '0;
      r_shift      <= '0;
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_sync       <= {r_sync[0], UART_RX};
      r_state      <= w_state_d;
      r_baudcnt    <= w_baudcnt_d;
      r_bitcnt     <= w_bitcnt_d;
      r_shift      <= w_shift_d;
      r_par_bad    <= w_par_bad_d;
      r_parity_err <= w_parity_err_d;
      r_frame_err  <= w_frame_err_d;
      r_overrun    <= w_overrun_d;
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_baudcnt_d    = r_baudcnt + 1'b1;
    w_bitcnt_d     = r_bitcnt;
    w_shift_d      = r_shift;
    w_par_bad_d    = r_par_bad;
    w_parity_err_d = 1'b0;
    w_frame_err_d  = 1'b0;
    w_overrun_d    = 1'b0;
    w_push         = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_baudcnt_d = '0;
        w_par_bad_d = 1'b0;
        if (!w_rxs) w_state_d = StStart;
      end
      StStart: begin
        if (r_baudcnt == HALF_LAST) begin
          w_baudcnt_d = '0;
          w_bitcnt_d  = '0;
          w_state_d   = w_rxs ? StIdle : StData;
        end
      end
      StData: begin
        if (w_baud_tick) begin
          w_baudcnt_d = '0;
          w_shift_d   = {w_rxs, r_shift[DATA_BITS-1:1]};
          w_bitcnt_d  = r_bitcnt + 1'b1;
          if (r_bitcnt == LAST_BIT) w_state_d = (PARITY != PAR_NONE) ? StParity : StStop;
        end
      end
      StParity: begin
        if (w_baud_tick) begin
          w_baudcnt_d = '0;
          w_par_bad_d = ((^r_shift) ^ w_rxs) != ODD_PAR;
          w_state_d   = StStop;
        end
      end
      StStop: begin
        if (w_baud_tick) begin
          w_baudcnt_d = '0;
          w_state_d   = StIdle;
          if (!w_rxs)                w_frame_err_d  = 1'b1;
          else if (r_par_bad)        w_parity_err_d = 1'b1;
          else if (w_full && !w_pop) w_overrun_d    = 1'b1;
          else                       w_push         = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (sysclk),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_wdata (r_shift),
    .i_pop   (w_pop),
    .o_rdata (rx_data),
    .o_valid (rx_valid),
    .o_full  (w_full),
    .o_count (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three instances (8N1, 8E1, 7O1) at DIV = 10, checked against a
// frame-level queue model with directed and randomised frames.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int          DIV    = CLK_HZ / BAUD;
  localparam int          DEPTH  = 4;

  logic       sysclk   = 1'b0;
  logic       reset    = 1'b0;
  logic [2:0] rx_line  = 3'b111;
  logic [2:0] rx_ready = 3'b000;
  logic [2:0] rx_valid, parity_err, frame_err, overrun;
  logic [2:0] fifo_count [3];
  logic [7:0] data0, data1;
  logic [6:0] data2;

  int n_tests = 0;
  int n_fail  = 0;
  int perr_cnt [3] = '{0, 0, 0};
  int ferr_cnt [3] = '{0, 0, 0};
  int ovr_cnt  [3] = '{0, 0, 0};

  always #5 sysclk = ~sysclk;

  uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(PAR_NONE),
                  .FIFO_DEPTH(DEPTH)) u_dut_n (
    .sysclk(sysclk), .reset(reset), .UART_RX(rx_line[0]), .rx_data(data0),
    .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]), .parity_err(parity_err[0]),
    .frame_err(frame_err[0]), .overrun(overrun[0]), .fifo_count(fifo_count[0]));

  uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(PAR_EVEN),
                  .FIFO_DEPTH(DEPTH)) u_dut_e (
    .sysclk(sysclk), .reset(reset), .UART_RX(rx_line[1]), .rx_data(data1),
    .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]), .parity_err(parity_err[1]),
    .frame_err(frame_err[1]), .overrun(overrun[1]), .fifo_count(fifo_count[1]));

  uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(PAR_ODD),
                  .FIFO_DEPTH(DEPTH)) u_dut_o (
    .sysclk(sysclk), .reset(reset), .UART_RX(rx_line[2]), .rx_data(data2),
    .rx_valid(rx_valid[2]), .rx_ready(rx_ready[2]), .parity_err(parity_err[2]),
    .frame_err(frame_err[2]), .overrun(overrun[2]), .fifo_count(fifo_count[2]));

  always @(posedge sysclk) begin
    for (int k = 0; k < 3; k++) begin
      if (parity_err[k] === 1'b1) perr_cnt[k] <= perr_cnt[k] + 1;
      if (frame_err[k] === 1'b1)  ferr_cnt[k] <= ferr_cnt[k] + 1;
      if (overrun[k] === 1'b1)    ovr_cnt[k]  <= ovr_cnt[k] + 1;
    end
  end

  function automatic int dbits(input int k);
    return (k == 2) ? 7 : 8;
  endfunction

  function automatic int pmode(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 1);
  endfunction

  function automatic int frame_len(input int k);
    return 2 + dbits(k) + ((pmode(k) != 0) ? 1 : 0);
  endfunction

  // Line driven low at iteration 0 reaches rxs two edges later; the stop sample follows
  // DIV/2 + (bits-1)*DIV cycles after that, and its result is visible one edge on.
  function automatic int stop_cyc(input int k);
    return 2 + DIV / 2 + (frame_len(k) - 1) * DIV;
  endfunction

  function automatic logic good_par(input int k, input logic [8:0] d);
    logic x;
    x = 1'b0;
    for (int i = 0; i < dbits(k); i++) x ^= d[i];
    return (pmode(k) == 2) ? x : ~x;
  endfunction

  function automatic logic [8:0] head(input int k);
    case (k)
      0:       return {1'b0, data0};
      1:       return {1'b0, data1};
      default: return {2'b00, data2};
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic send_frame(input int k, input logic [8:0] d, input logic par_flip,
                            input logic stop_bit, input int pop_cyc, output int rise_cyc);
    logic       bits [12];
    int         nb;
    logic [2:0] c0;
    nb = frame_len(k);
    bits[0] = 1'b0;
    for (int i = 0; i < dbits(k); i++) bits[1 + i] = d[i];
    if (pmode(k) != 0) bits[1 + dbits(k)] = good_par(k, d) ^ par_flip;
    bits[nb - 1] = stop_bit;
    c0 = fifo_count[k];
    rise_cyc = -1;
    for (int cyc = 0; cyc < nb * DIV; cyc++) begin
      rx_line[k]  = bits[cyc / DIV];
      rx_ready[k] = (cyc == pop_cyc);
      tick(1);
      if (rise_cyc < 0 && fifo_count[k] !== c0) rise_cyc = cyc;
    end
    rx_ready[k] = 1'b0;
    rx_line[k]  = 1'b1;
  endtask

  task automatic do_pop(input int k, output logic valid, output logic [8:0] data);
    valid = rx_valid[k];
    data  = head(k);
    rx_ready[k] = 1'b1;
    tick(1);
    rx_ready[k] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (rx_valid[k] !== 1'b0 || fifo_count[k] !== 3'd0 || head(k) !== 9'h000 ||
          parity_err[k] !== 1'b0 || frame_err[k] !== 1'b0 || overrun[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset dut%0d: valid=%b count=%0d data=%h errs=%b%b%b, required all zero",
                 k, rx_valid[k], fifo_count[k], head(k), parity_err[k], frame_err[k],
                 overrun[k]);
      end
    end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_basic();
    int rise;
    logic v;
    logic [8:0] d;
    send_frame(0, 9'h02D, 1'b0, 1'b1, -1, rise);
    n_tests++;
    if (rise !== stop_cyc(0)) begin
      n_fail++;
      $display("FAIL basic_latency: rx_valid rose at cycle %0d, required %0d", rise, stop_cyc(0));
    end
    n_tests++;
    if (rx_valid[0] !== 1'b1 || head(0) !== 9'h02D || fifo_count[0] !== 3'd1) begin
      n_fail++;
      $display("FAIL basic_data: valid=%b data=%h count=%0d, required 1/02d/1",
               rx_valid[0], head(0), fifo_count[0]);
    end
    do_pop(0, v, d);
    n_tests++;
    if (rx_valid[0] !== 1'b0 || fifo_count[0] !== 3'd0) begin
      n_fail++;
      $display("FAIL basic_pop: valid=%b count=%0d, required 0/0", rx_valid[0], fifo_count[0]);
    end
  endtask

  task automatic test_even_parity();
    int rise, p0;
    logic v;
    logic [8:0] d;
    p0 = perr_cnt[1];
    send_frame(1, 9'h02D, 1'b0, 1'b1, -1, rise);
    n_tests++;
    if (fifo_count[1] !== 3'd1 || head(1) !== 9'h02D || perr_cnt[1] != p0) begin
      n_fail++;
      $display("FAIL even_good: count=%0d data=%h perr=%0d, required 1/02d/0",
               fifo_count[1], head(1), perr_cnt[1] - p0);
    end
    send_frame(1, 9'h02D, 1'b1, 1'b1, -1, rise);
    n_tests++;
    if (fifo_count[1] !== 3'd1 || perr_cnt[1] != p0 + 1) begin
      n_fail++;
      $display("FAIL even_bad: count=%0d perr pulses=%0d, required 1/1",
               fifo_count[1], perr_cnt[1] - p0);
    end
    do_pop(1, v, d);
    n_tests++;
    if (v !== 1'b1 || d !== 9'h02D || rx_valid[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL even_pop: valid=%b data=%h after=%b, required 1/02d/0", v, d, rx_valid[1]);
    end
  endtask

  task automatic test_frame_err();
    int rise, f0;
    logic v;
    logic [8:0] d;
    f0 = ferr_cnt[0];
    send_frame(0, 9'h055, 1'b0, 1'b0, -1, rise);
    tick(2 * DIV);
    n_tests++;
    if (ferr_cnt[0] != f0 + 1 || fifo_count[0] !== 3'd0) begin
      n_fail++;
      $display("FAIL frame_err: pulses=%0d count=%0d, required 1/0",
               ferr_cnt[0] - f0, fifo_count[0]);
    end
    send_frame(0, 9'h00C, 1'b0, 1'b1, -1, rise);
    n_tests++;
    if (fifo_count[0] !== 3'd1 || head(0) !== 9'h00C || ferr_cnt[0] != f0 + 1) begin
      n_fail++;
      $display("FAIL frame_recover: count=%0d data=%h pulses=%0d, required 1/00c/1",
               fifo_count[0], head(0), ferr_cnt[0] - f0);
    end
    do_pop(0, v, d);
  endtask

  task automatic test_overrun();
    int rise, o0;
    logic v;
    logic [8:0] d;
    o0 = ovr_cnt[0];
    for (int i = 1; i <= 5; i++) send_frame(0, 9'(i), 1'b0, 1'b1, -1, rise);
    n_tests++;
    if (fifo_count[0] !== 3'd4 || ovr_cnt[0] != o0 + 1) begin
      n_fail++;
      $display("FAIL overrun: count=%0d pulses=%0d, required 4/1",
               fifo_count[0], ovr_cnt[0] - o0);
    end
    for (int i = 1; i <= 4; i++) begin
      do_pop(0, v, d);
      n_tests++;
      if (v !== 1'b1 || d !== 9'(i)) begin
        n_fail++;
        $display("FAIL overrun_pop%0d: valid=%b data=%h, required 1/%h", i, v, d, 9'(i));
      end
    end
    n_tests++;
    if (rx_valid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_empty: valid=%b, required 0", rx_valid[0]);
    end
  endtask

  task automatic test_glitch_push_full();
    int rise, e0, o0;
    logic v;
    logic [8:0] d;
    e0 = perr_cnt[0] + ferr_cnt[0] + ovr_cnt[0];
    rx_line[0] = 1'b0;
    tick(3);
    rx_line[0] = 1'b1;
    tick(3 * DIV);
    n_tests++;
    if (fifo_count[0] !== 3'd0 || perr_cnt[0] + ferr_cnt[0] + ovr_cnt[0] != e0) begin
      n_fail++;
      $display("FAIL glitch: count=%0d err pulses=%0d, required 0/0",
               fifo_count[0], perr_cnt[0] + ferr_cnt[0] + ovr_cnt[0] - e0);
    end
    for (int i = 0; i < 4; i++) send_frame(0, 9'h010 + 9'(i), 1'b0, 1'b1, -1, rise);
    o0 = ovr_cnt[0];
    send_frame(0, 9'h014, 1'b0, 1'b1, stop_cyc(0), rise);
    n_tests++;
    if (fifo_count[0] !== 3'd4 || ovr_cnt[0] != o0 || head(0) !== 9'h011) begin
      n_fail++;
      $display("FAIL push_while_full: count=%0d overruns=%0d head=%h, required 4/0/011",
               fifo_count[0], ovr_cnt[0] - o0, head(0));
    end
    for (int i = 1; i <= 4; i++) begin
      do_pop(0, v, d);
      n_tests++;
      if (v !== 1'b1 || d !== 9'h010 + 9'(i)) begin
        n_fail++;
        $display("FAIL full_pop%0d: valid=%b data=%h, required 1/%h", i, v, d, 9'h010 + 9'(i));
      end
    end
  endtask

  task automatic test_reset_midframe();
    int rise;
    logic v;
    logic [8:0] d;
    send_frame(0, 9'h033, 1'b0, 1'b1, -1, rise);
    for (int cyc = 0; cyc < 35; cyc++) begin
      rx_line[0] = (cyc < DIV) ? 1'b0 : ((cyc < 2 * DIV) ? 1'b1 : 1'b0);
      tick(1);
    end
    reset   = 1'b1;
    rx_line = 3'b111;
    tick(2);
    n_tests++;
    if (rx_valid[0] !== 1'b0 || fifo_count[0] !== 3'd0 || head(0) !== 9'h000 ||
        frame_err[0] !== 1'b0 || parity_err[0] !== 1'b0 || overrun[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midframe: valid=%b count=%0d data=%h, required 0/0/000",
               rx_valid[0], fifo_count[0], head(0));
    end
    reset = 1'b0;
    tick(3 * DIV);
    n_tests++;
    if (rx_valid[0] !== 1'b0 || fifo_count[0] !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_abandon: valid=%b count=%0d, required 0/0", rx_valid[0],
               fifo_count[0]);
    end
    send_frame(2, 9'h05A, 1'b0, 1'b1, -1, rise);
    n_tests++;
    if (rise !== stop_cyc(2) || head(2) !== 9'h05A || fifo_count[2] !== 3'd1) begin
      n_fail++;
      $display("FAIL odd7: rise=%0d data=%h count=%0d, required %0d/05a/1",
               rise, head(2), fifo_count[2], stop_cyc(2));
    end
    do_pop(2, v, d);
  endtask

  task automatic test_random();
    int rise, r, f0, p0, o0, ef, ep, eo;
    logic stop, pflip, v;
    logic [8:0] d, got, exp_d, mask;
    logic [8:0] q[$];
    for (int k = 0; k < 3; k++) begin
      q.delete();
      ef = 0; ep = 0; eo = 0;
      f0 = ferr_cnt[k]; p0 = perr_cnt[k]; o0 = ovr_cnt[k];
      mask = (dbits(k) == 8) ? 9'h0FF : 9'h07F;
      repeat (14) begin
        d     = 9'($urandom) & mask;
        r     = $urandom_range(0, 7);
        stop  = (r != 0);
        pflip = (pmode(k) != 0) && (r == 1);
        send_frame(k, d, pflip, stop, -1, rise);
        if (!stop) begin
          ef++;
          tick(2 * DIV);
        end else if (pflip) ep++;
        else if (q.size() == DEPTH) eo++;
        else q.push_back(d);
        n_tests++;
        if (fifo_count[k] !== 3'(q.size())) begin
          n_fail++;
          $display("FAIL rand_count dut%0d: count=%0d, required %0d", k, fifo_count[k],
                   q.size());
        end
        if ($urandom_range(0, 2) == 0) begin
          do_pop(k, v, got);
          n_tests++;
          if (q.size() > 0) begin
            exp_d = q.pop_front();
            if (v !== 1'b1 || got !== exp_d) begin
              n_fail++;
              $display("FAIL rand_pop dut%0d: valid=%b data=%h, required 1/%h", k, v, got, exp_d);
            end
          end else if (v !== 1'b0 || fifo_count[k] !== 3'd0) begin
            n_fail++;
            $display("FAIL rand_pop_empty dut%0d: valid=%b count=%0d, required 0/0",
                     k, v, fifo_count[k]);
          end
        end
        tick($urandom_range(0, 12));
      end
      while (q.size() > 0) begin
        exp_d = q.pop_front();
        do_pop(k, v, got);
        n_tests++;
        if (v !== 1'b1 || got !== exp_d) begin
          n_fail++;
          $display("FAIL rand_drain dut%0d: valid=%b data=%h, required 1/%h", k, v, got, exp_d);
        end
      end
      n_tests++;
      if (ferr_cnt[k] - f0 != ef || perr_cnt[k] - p0 != ep || ovr_cnt[k] - o0 != eo) begin
        n_fail++;
        $display("FAIL rand_errs dut%0d: frame/parity/overrun=%0d/%0d/%0d, required %0d/%0d/%0d",
                 k, ferr_cnt[k] - f0, perr_cnt[k] - p0, ovr_cnt[k] - o0, ef, ep, eo);
      end
    end
  endtask

  initial begin
    tick(1);
    test_reset();
    test_basic();
    test_even_parity();
    test_frame_err();
    test_overrun();
    test_glitch_push_full();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
